// File: rtl/aste_pkg.sv
// Shared types for the asteroid table: default field widths, direction codes,
// the packed {x, y, dir} entry and helpers to move between entry and raw bits.
package aste_pkg;

  localparam int ASTE_X_W   = 4;
  localparam int ASTE_Y_W   = 4;
  localparam int ASTE_DIR_W = 2;
  localparam int ASTE_DEPTH = 16;
  localparam int ASTE_EW    = ASTE_X_W + ASTE_Y_W + ASTE_DIR_W;

  typedef enum logic [ASTE_DIR_W-1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } aste_dir_t;

  typedef struct packed {
    logic [ASTE_X_W-1:0] x;
    logic [ASTE_Y_W-1:0] y;
    aste_dir_t           dir;
  } aste_entry_t;

  function automatic logic [ASTE_EW-1:0] aste_pack(input aste_entry_t e);
    return e;
  endfunction

  function automatic aste_entry_t aste_unpack(input logic [ASTE_EW-1:0] v);
    return aste_entry_t'(v);
  endfunction

endpackage

// File: rtl/memoria_aste_tab_if.sv
// Bus between the game-logic FSM / renderer (master) and the asteroid table (slave).
// Optional second read port enabled by macro ASTE_DUAL_READ_EN.
interface memoria_aste_tab_if
  import aste_pkg::*;
#(
  parameter int X_W   = ASTE_X_W,
  parameter int Y_W   = ASTE_Y_W,
  parameter int DIR_W = ASTE_DIR_W,
  parameter int DEPTH = ASTE_DEPTH
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = X_W + Y_W + DIR_W;

  logic          we;
  logic          kill;
  logic [AW-1:0] addr;
  logic [EW-1:0] data;
  logic [EW-1:0] q;
  logic          q_valid;
  logic          alloc;
  logic [EW-1:0] alloc_data;
  logic          alloc_ack;
  logic [AW-1:0] alloc_addr;
  logic [AW:0]   count;
  logic          full;
  logic          ready;

`ifdef ASTE_DUAL_READ_EN
  logic [AW-1:0] addr_b;
  logic [EW-1:0] q_b;
  logic          q_b_valid;

  modport master (
    output we, kill, addr, data, alloc, alloc_data, addr_b,
    input  q, q_valid, alloc_ack, alloc_addr, count, full, ready, q_b, q_b_valid
  );
  modport slave (
    input  we, kill, addr, data, alloc, alloc_data, addr_b,
    output q, q_valid, alloc_ack, alloc_addr, count, full, ready, q_b, q_b_valid
  );
`else
  modport master (
    output we, kill, addr, data, alloc, alloc_data,
    input  q, q_valid, alloc_ack, alloc_addr, count, full, ready
  );
  modport slave (
    input  we, kill, addr, data, alloc, alloc_data,
    output q, q_valid, alloc_ack, alloc_addr, count, full, ready
  );
`endif

endinterface

// File: rtl/aste_free_enc.sv
// Lowest-zero priority encoder: index of the first free (invalid) slot.
module aste_free_enc #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_i,
  output logic [AW-1:0]    idx_o,
  output logic             none_free_o
);

  // Scanning from the top down lets the lowest free slot be the last to win.
  always_comb begin
    idx_o       = '0;
    none_free_o = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        idx_o       = AW'(i);
        none_free_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/memoria_aste_tab.sv
// Asteroid table: DEPTH slots of {x,y,dir} + valid, with allocation, kill, occupancy
// count and a clear sweep after reset. Macro ASTE_DUAL_READ_EN adds a second read port.
module memoria_aste_tab
  import aste_pkg::*;
#(
  parameter int X_W   = ASTE_X_W,
  parameter int Y_W   = ASTE_Y_W,
  parameter int DIR_W = ASTE_DIR_W,
  parameter int DEPTH = ASTE_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  memoria_aste_tab_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          EW       = X_W + Y_W + DIR_W;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  typedef enum logic {ST_CLR, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q;
  logic [AW:0]   count_q, count_d;
  logic          alloc_ack_q, alloc_ack_d;
  logic [AW-1:0] alloc_addr_q, alloc_addr_d;
  logic [EW-1:0] ram_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [EW-1:0] mem_wdata;
  logic          vld_we;
  logic          vld_set;
  logic [AW-1:0] free_idx;
  logic          none_free;

  aste_free_enc #(.DEPTH(DEPTH), .AW(AW)) u_free_enc (
    .valid_i    (valid_q),
    .idx_o      (free_idx),
    .none_free_o(none_free)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    alloc_ack_d  = 1'b0;
    alloc_addr_d = alloc_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = bus.addr;
    mem_wdata    = bus.data;
    vld_we       = 1'b0;
    vld_set      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_CLR: begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = '0;
          vld_we    = 1'b1;
          ptr_d     = ptr_q + AW'(1);
          if (ptr_q == PTR_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Priority: write, then kill, then allocation.
          if (bus.we) begin
            mem_we  = 1'b1;
            vld_we  = 1'b1;
            vld_set = 1'b1;
            if (!valid_q[bus.addr]) count_d = count_q + CNT_ONE;
          end else if (bus.kill) begin
            vld_we = 1'b1;
            if (valid_q[bus.addr]) count_d = count_q - CNT_ONE;
          end else if (bus.alloc && !none_free) begin
            mem_we       = 1'b1;
            mem_waddr    = free_idx;
            mem_wdata    = bus.alloc_data;
            vld_we       = 1'b1;
            vld_set      = 1'b1;
            count_d      = count_q + CNT_ONE;
            alloc_ack_d  = 1'b1;
            alloc_addr_d = free_idx;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLR;
      ptr_q        <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      alloc_ack_q  <= 1'b0;
      alloc_addr_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      addr_q       <= bus.addr;
      count_q      <= count_d;
      alloc_ack_q  <= alloc_ack_d;
      alloc_addr_q <= alloc_addr_d;
      if (vld_we) valid_q[mem_waddr] <= vld_set;
    end
  end

  // NOTE: the data array has no reset; the clear sweep zeroes it, which keeps
  // the storage free of reset fan-out.
  always_ff @(posedge clk) begin
    if (mem_we) ram_q[mem_waddr] <= mem_wdata;
  end

  assign bus.q          = ram_q[addr_q];
  assign bus.q_valid    = valid_q[addr_q];
  assign bus.alloc_ack  = alloc_ack_q;
  assign bus.alloc_addr = alloc_addr_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == CNT_FULL);
  assign bus.ready      = (state_q == ST_RUN);

`ifdef ASTE_DUAL_READ_EN
  logic [AW-1:0] addr_b_q;

  always_ff @(posedge clk) begin
    if (reset) addr_b_q <= '0;
    else       addr_b_q <= bus.addr_b;
  end

  // Renderer port shows zeros while the sweep has not finished.
  assign bus.q_b       = (state_q == ST_RUN) ? ram_q[addr_b_q] : '0;
  assign bus.q_b_valid = valid_q[addr_b_q];
`endif

endmodule

// File: tb/tb_memoria_aste_tab.sv
// Directed bench for memoria_aste_tab: sweep, allocation, kill, priority, reset restart
// and, with ASTE_DUAL_READ_EN, the second read port.
module tb_memoria_aste_tab;
  import aste_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  memoria_aste_tab_if bus ();

  memoria_aste_tab dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_wait();
    repeat (15) tick();
    check("ready_low_15", 32'(bus.ready), 32'd0);
    tick();
    check("ready_high_16", 32'(bus.ready), 32'd1);
  endtask

  task automatic scan_empty(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      tick();
      check({tag, "_q"}, 32'(bus.q), 32'd0);
      check({tag, "_qv"}, 32'(bus.q_valid), 32'd0);
    end
  endtask

  logic [9:0]  d1, d2, d3;
  aste_entry_t e;

  initial begin
    e.x = 4'd7;  e.y = 4'd14; e.dir = DIR_DOWN; d1 = aste_pack(e); // 0111_1110_11
    e.x = 4'd14; e.y = 4'd7;  e.dir = DIR_LEFT; d2 = aste_pack(e); // 1110_0111_01
    e.x = 4'd3;  e.y = 4'd5;  e.dir = DIR_UP;   d3 = aste_pack(e); // 0011_0101_10

    bus.we = 1'b0; bus.kill = 1'b0; bus.addr = '0; bus.data = '0;
    bus.alloc = 1'b0; bus.alloc_data = '0;
`ifdef ASTE_DUAL_READ_EN
    bus.addr_b = '0;
`endif
    reset = 1'b1;

    // 1: reset state, sweep length, empty table
    tick(); tick();
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_ack", 32'(bus.alloc_ack), 32'd0);
    check("rst_aaddr", 32'(bus.alloc_addr), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_qv", 32'(bus.q_valid), 32'd0);
    reset = 1'b0;
    sweep_wait();
    scan_empty("t1");
    check("t1_count", 32'(bus.count), 32'd0);

    // 2: fill all slots, 17th request unserved
    bus.alloc = 1'b1; bus.alloc_data = d1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i < 16) begin
        check("t2_ack", 32'(bus.alloc_ack), 32'd1);
        check("t2_aaddr", 32'(bus.alloc_addr), 32'(i));
        check("t2_count", 32'(bus.count), 32'(i + 1));
      end else begin
        check("t2_noack", 32'(bus.alloc_ack), 32'd0);
        check("t2_aaddr_hold", 32'(bus.alloc_addr), 32'd15);
      end
    end
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_count16", 32'(bus.count), 32'd16);
    bus.alloc = 1'b0;

    // 3: kill slot 5, reallocate into it
    bus.kill = 1'b1; bus.addr = 4'd5;
    tick();
    bus.kill = 1'b0;
    check("t3_count_kill", 32'(bus.count), 32'd15);
    check("t3_notfull", 32'(bus.full), 32'd0);
    bus.alloc = 1'b1; bus.alloc_data = d2;
    tick();
    bus.alloc = 1'b0;
    check("t3_ack", 32'(bus.alloc_ack), 32'd1);
    check("t3_aaddr", 32'(bus.alloc_addr), 32'd5);
    tick();
    check("t3_q5", 32'(bus.q), 32'(d2));
    check("t3_q5_x", 32'(aste_unpack(bus.q).x), 32'd14);
    check("t3_qv5", 32'(bus.q_valid), 32'd1);
    check("t3_count", 32'(bus.count), 32'd16);

    // 4: we+kill on slot 3 with alloc pending
    bus.kill = 1'b1; bus.addr = 4'd3; tick();
    bus.addr = 4'd9; tick();
    tick();
    check("t4_kill_empty", 32'(bus.count), 32'd14);
    bus.kill = 1'b1; bus.we = 1'b1; bus.addr = 4'd3; bus.data = d3;
    bus.alloc = 1'b1; bus.alloc_data = d1;
    tick();
    check("t4_noack", 32'(bus.alloc_ack), 32'd0);
    check("t4_count", 32'(bus.count), 32'd15);
    bus.we = 1'b0; bus.kill = 1'b0;
    tick();
    bus.alloc = 1'b0;
    check("t4_ack", 32'(bus.alloc_ack), 32'd1);
    check("t4_aaddr", 32'(bus.alloc_addr), 32'd9);
    check("t4_full", 32'(bus.full), 32'd1);
    tick();
    check("t4_q3", 32'(bus.q), 32'(d3));
    check("t4_qv3", 32'(bus.q_valid), 32'd1);

    // same-address write: old data before the edge, new after
    bus.addr = 4'd0; tick();
    bus.we = 1'b1; bus.data = d2;
    check("rw_old", 32'(bus.q), 32'(d1));
    tick();
    bus.we = 1'b0;
    check("rw_new", 32'(bus.q), 32'(d2));
    check("rw_count", 32'(bus.count), 32'd16);

`ifdef ASTE_DUAL_READ_EN
    // 6: second read port
    bus.addr_b = 4'd2; tick();
    check("t6_qb_old", 32'(bus.q_b), 32'(d1));
    bus.we = 1'b1; bus.addr = 4'd2; bus.data = d3;
    tick();
    bus.we = 1'b0;
    check("t6_qb_new", 32'(bus.q_b), 32'(d3));
    bus.we = 1'b1; bus.addr = 4'd9; bus.data = d2; tick();
    bus.we = 1'b0; bus.addr = 4'd2; bus.addr_b = 4'd9;
    tick();
    check("t6_qa", 32'(bus.q), 32'(d3));
    check("t6_qb", 32'(bus.q_b), 32'(d2));
    check("t6_qbv", 32'(bus.q_b_valid), 32'd1);
`endif

    // 5: reset during the sweep, then during RUN
    reset = 1'b1; tick();
    reset = 1'b0;
    repeat (7) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    sweep_wait();
    check("t5_count0", 32'(bus.count), 32'd0);
    bus.alloc = 1'b1; bus.alloc_data = d3;
    repeat (9) tick();
    bus.alloc = 1'b0;
    check("t5_count9", 32'(bus.count), 32'd9);
    reset = 1'b1; tick();
    check("t5_rst_count", 32'(bus.count), 32'd0);
    check("t5_rst_ready", 32'(bus.ready), 32'd0);
    check("t5_rst_aaddr", 32'(bus.alloc_addr), 32'd0);
    reset = 1'b0;
    sweep_wait();
    scan_empty("t5");
    check("t5_count", 32'(bus.count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
